// File: rtl/key_ctrl_pkg.sv
// key_ctrl_pkg: shared types, defaults and a CRC-8 reference step for the key unlock controller
package key_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_KEY,
        S_SHIFT_CRC,
        S_CHECK,
        S_ARMED,
        S_ERROR,
        S_LOCKOUT
    } kc_state_t;

    localparam int KEY_W_DEF = 32;
    localparam int CRC_W_DEF = 8;
    localparam logic [7:0] CRC_POLY_DEF = 8'h07;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC_POLY_DEF : 8'h00);
    endfunction

endpackage

// File: rtl/crc_serial.sv
// crc_serial: bit-serial MSB-first CRC register, init 0, no reflection, no final XOR
module crc_serial #(
    parameter int CRC_W = 8,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'('h07)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);
    logic [CRC_W-1:0] crc_q, crc_d;

    always_comb begin
        crc_d = clr ? '0
              : en  ? ({crc_q[CRC_W-2:0], 1'b0} ^ ((crc_q[CRC_W-1] ^ bit_in) ? CRC_POLY : '0))
              : crc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= '0;
        else        crc_q <= crc_d;
    end

    assign crc = crc_q;
endmodule

// File: rtl/key_unlock_ctrl.sv
// key_unlock_ctrl: serially loads a CRC-protected unlock key and arms it onto the locked core's key pins
module key_unlock_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int CRC_W = CRC_W_DEF,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC_POLY_DEF),
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             kin_valid,
    input  logic             kin_bit,
    output logic             kin_ready,
    input  logic             zeroize,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             load_err,
    output logic             lockout,
    output logic             busy
);
    localparam int CNT_W = $clog2(KEY_W);
    localparam int FCW   = $clog2(MAX_FAIL + 1);

    kc_state_t        state_q, state_d;
    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CRC_W-1:0] rx_q, rx_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [FCW-1:0]   fail_cnt_q, fail_cnt_d;
    logic             key_valid_q, key_valid_d;
    logic             load_err_q, load_err_d;
    logic [CRC_W-1:0] crc;
    logic             wipe, start, xfer, crc_ok, key_last, crc_last;

    // Lockout is terminal: even zeroize cannot leave it, only rst_n.
    assign wipe     = zeroize && state_q != S_LOCKOUT;
    assign start    = !wipe && load_start && (state_q == S_IDLE || state_q == S_ERROR);
    assign xfer     = kin_valid && kin_ready;
    assign crc_ok   = crc == rx_q;
    assign key_last = bit_cnt_q == CNT_W'(KEY_W - 1);
    assign crc_last = bit_cnt_q == CNT_W'(CRC_W - 1);

    crc_serial #(.CRC_W(CRC_W), .CRC_POLY(CRC_POLY)) u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wipe || start),
        .en     (state_q == S_SHIFT_KEY && xfer),
        .bit_in (kin_bit),
        .crc    (crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (wipe) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_ERROR: state_d = load_start ? S_SHIFT_KEY : state_q;
                S_SHIFT_KEY:     state_d = (xfer && key_last) ? S_SHIFT_CRC : state_q;
                S_SHIFT_CRC:     state_d = (xfer && crc_last) ? S_CHECK : state_q;
                S_CHECK:         state_d = crc_ok ? S_ARMED
                                         : (fail_cnt_q == FCW'(MAX_FAIL - 1)) ? S_LOCKOUT : S_ERROR;
                default:         state_d = state_q;
            endcase
        end
    end

    always_comb begin
        kin_ready = state_q == S_SHIFT_KEY || state_q == S_SHIFT_CRC;
        busy      = kin_ready || state_q == S_CHECK;
        lockout   = state_q == S_LOCKOUT;
        key_out   = key_q;
        key_valid = key_valid_q;
        load_err  = load_err_q;
    end

    // key_q is only written on a CRC pass or a wipe, so partial shadow contents never reach the core.
    always_comb begin
        shadow_d    = shadow_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        load_err_d  = load_err_q;
        fail_cnt_d  = fail_cnt_q;
        if (wipe) begin
            shadow_d    = '0;
            rx_d        = '0;
            bit_cnt_d   = '0;
            key_d       = '0;
            key_valid_d = 1'b0;
            load_err_d  = 1'b0;
        end else if (start) begin
            shadow_d   = '0;
            rx_d       = '0;
            bit_cnt_d  = '0;
            load_err_d = 1'b0;
        end else if (state_q == S_SHIFT_KEY && xfer) begin
            shadow_d[bit_cnt_q] = kin_bit;
            bit_cnt_d           = key_last ? '0 : bit_cnt_q + 1'b1;
        end else if (state_q == S_SHIFT_CRC && xfer) begin
            rx_d      = {rx_q[CRC_W-2:0], kin_bit};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (state_q == S_CHECK) begin
            if (crc_ok) begin
                key_d       = shadow_q;
                key_valid_d = 1'b1;
            end else begin
                fail_cnt_d = fail_cnt_q + FCW'(fail_cnt_q != FCW'(MAX_FAIL));
                load_err_d = 1'b1;
                shadow_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            load_err_q  <= 1'b0;
            fail_cnt_q  <= '0;
        end else begin
            shadow_q    <= shadow_d;
            rx_q        <= rx_d;
            bit_cnt_q   <= bit_cnt_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            load_err_q  <= load_err_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end
endmodule
